// File: rtl/mem_port_arbiter.sv
// -----------------------------------------------------------------------------
// mem_port_arbiter
//
// Shares the single-port unified MEM between the instruction-fetch requester
// (i_*) and the load/store requester (d_*) of the multicycle CPU.
// Every access takes exactly three cycles: IDLE (grant) -> BUSY (MEM access)
// -> RESP (ack pulse). Illegal accesses (misaligned, out of range, or a store
// into the protected text area) are answered with err=1 and rdata=0, and they
// never assert mem_R or mem_W.
//
// Optional feature, selected by the macro ARB_ROUND_ROBIN_EN:
//   defined     : on a simultaneous request, grant the requester that did not
//                 get the previous grant (last_grant updates on every grant).
//   not defined : fixed priority, the data requester wins every tie.
//
// Ports
//   clk, rst_n                 clock (rising edge), async active-low reset
//   i_req/i_addr               fetch request, held until i_ack
//   i_ack/i_rdata/i_err        fetch completion pulse, registered data, error
//   d_req/d_we/d_addr/d_wdata  load/store request, held until d_ack
//   d_ack/d_rdata/d_err        data completion pulse, registered data, error
//   mem_addr/mem_R/mem_W/
//   mem_wdata                  MEM control, driven only during BUSY
//   mem_rdata                  MEM combinational read data
//   busy                       high whenever the FSM is not in IDLE
// -----------------------------------------------------------------------------
module mem_port_arbiter #(
  parameter int unsigned MEM_BYTES  = 4096,
  parameter logic [31:0] PROT_LIMIT = 32'h400
) (
  input  logic        clk,
  input  logic        rst_n,
  // Fetch requester
  input  logic        i_req,
  input  logic [31:0] i_addr,
  output logic        i_ack,
  output logic [31:0] i_rdata,
  output logic        i_err,
  // Load/store requester
  input  logic        d_req,
  input  logic        d_we,
  input  logic [31:0] d_addr,
  input  logic [31:0] d_wdata,
  output logic        d_ack,
  output logic [31:0] d_rdata,
  output logic        d_err,
  // MEM side
  output logic [31:0] mem_addr,
  output logic        mem_R,
  output logic        mem_W,
  output logic [31:0] mem_wdata,
  input  logic [31:0] mem_rdata,
  // Status
  output logic        busy
);

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_BUSY = 2'd1;
  localparam logic [1:0] ST_RESP = 2'd2;

  localparam logic GNT_FETCH = 1'b0;
  localparam logic GNT_DATA  = 1'b1;

  localparam logic [31:0] MEM_LIMIT = 32'(MEM_BYTES);

  logic [1:0]  state;
  logic [1:0]  state_nxt;
  logic        grant_q;     // owner of the access in flight
  logic [31:0] lat_addr;
  logic [31:0] lat_wdata;
  logic        lat_we;
  logic        lat_err;

  logic        any_req;
  logic        pick_data;   // 1: grant the data requester this cycle
  logic [31:0] sel_addr;
  logic [31:0] sel_wdata;
  logic        sel_we;
  logic        sel_err;

  logic        in_busy;
  logic        in_resp;

  assign any_req = i_req | d_req;
  assign in_busy = (state == ST_BUSY);
  assign in_resp = (state == ST_RESP);

  // ---------------------------------------------------------------------------
  // Arbitration
  // ---------------------------------------------------------------------------
`ifdef ARB_ROUND_ROBIN_EN
  logic last_grant;

  // A lone requester is always served; on a tie the one that did not win the
  // previous grant goes first.
  always_comb begin
    if (i_req && d_req) begin
      pick_data = (last_grant == GNT_FETCH);
    end else begin
      pick_data = d_req;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      last_grant <= GNT_FETCH;
    end else if (state == ST_IDLE && any_req) begin
      last_grant <= pick_data ? GNT_DATA : GNT_FETCH;
    end
  end
`else
  // Fixed priority: data wins any tie.
  assign pick_data = d_req;
`endif

  // ---------------------------------------------------------------------------
  // Request selection and legality check (evaluated in IDLE)
  // ---------------------------------------------------------------------------
  // A fetch is read-only, so its write-enable and write data are forced to 0;
  // that alone rules out the text-area store check for fetches.
  assign sel_addr  = pick_data ? d_addr : i_addr;
  assign sel_we    = pick_data & d_we;
  assign sel_wdata = pick_data ? d_wdata : 32'h0;

  always_comb begin
    // NOTE: every signal assigned in a combinational block gets a default
    // first; a path that leaves it unassigned would infer a latch.
    sel_err = 1'b0;
    if (sel_addr[1:0] != 2'b00) begin
      sel_err = 1'b1;
    end
    if (sel_addr >= MEM_LIMIT) begin
      sel_err = 1'b1;
    end
    if (sel_we && (sel_addr < PROT_LIMIT)) begin
      sel_err = 1'b1;
    end
  end

  // ---------------------------------------------------------------------------
  // FSM: IDLE -> BUSY -> RESP -> IDLE, one access per three cycles
  // ---------------------------------------------------------------------------
  always_comb begin
    state_nxt = state;
    case (state)
      ST_IDLE: if (any_req) state_nxt = ST_BUSY;
      ST_BUSY: state_nxt = ST_RESP;
      ST_RESP: state_nxt = ST_IDLE;
      default: state_nxt = ST_IDLE;
    endcase
  end

  // NOTE: sequential state is written with non-blocking assignments only, so
  // every register samples the pre-edge value of every other register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= ST_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Request latch. Cleared on reset as well so that an aborted access leaves
  // nothing behind that could reach the MEM pins.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      grant_q   <= GNT_FETCH;
      lat_addr  <= 32'h0;
      lat_wdata <= 32'h0;
      lat_we    <= 1'b0;
      lat_err   <= 1'b0;
    end else if (state == ST_IDLE && any_req) begin
      grant_q   <= pick_data ? GNT_DATA : GNT_FETCH;
      lat_addr  <= sel_addr;
      lat_wdata <= sel_wdata;
      lat_we    <= sel_we;
      lat_err   <= sel_err;
    end
  end

  // Read-data registers. MEM read data is captured at the edge that closes
  // BUSY, into the grantee's register only; the other register keeps its
  // value. A rejected access returns 0.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      i_rdata <= 32'h0;
      d_rdata <= 32'h0;
    end else if (in_busy) begin
      if (grant_q == GNT_DATA) begin
        d_rdata <= lat_err ? 32'h0 : mem_rdata;
      end else begin
        i_rdata <= lat_err ? 32'h0 : mem_rdata;
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Outputs
  // ---------------------------------------------------------------------------
  // MEM strobes decode straight from the state register: an asynchronous
  // reset forces IDLE and therefore drops mem_W in the same instant, which is
  // what aborts an in-flight store.
  assign mem_addr  = in_busy ? lat_addr  : 32'h0;
  assign mem_wdata = in_busy ? lat_wdata : 32'h0;
  assign mem_R     = in_busy & ~lat_we & ~lat_err;
  assign mem_W     = in_busy &  lat_we & ~lat_err;

  // Only one grantee exists per access, so the acks cannot overlap.
  assign i_ack = in_resp & (grant_q == GNT_FETCH);
  assign d_ack = in_resp & (grant_q == GNT_DATA);
  assign i_err = i_ack & lat_err;
  assign d_err = d_ack & lat_err;

  assign busy  = (state != ST_IDLE);

endmodule

// File: tb/tb_mem_port_arbiter.sv
// -----------------------------------------------------------------------------
// tb_mem_port_arbiter
//
// Self-checking bench for mem_port_arbiter. Holds a behavioural MEM (array
// with combinational read) and an independent reference model of the
// expected responses: legality from the address rules, read data from a
// shadow copy of memory updated only by legal stores, and grant order from
// the arbitration rule. Directed scenarios are followed by random traffic.
// -----------------------------------------------------------------------------
module tb_mem_port_arbiter;

  logic        clk;
  logic        rst_n;
  logic        i_req;
  logic [31:0] i_addr;
  logic        i_ack;
  logic [31:0] i_rdata;
  logic        i_err;
  logic        d_req;
  logic        d_we;
  logic [31:0] d_addr;
  logic [31:0] d_wdata;
  logic        d_ack;
  logic [31:0] d_rdata;
  logic        d_err;
  logic [31:0] mem_addr;
  logic        mem_R;
  logic        mem_W;
  logic [31:0] mem_wdata;
  logic [31:0] mem_rdata;
  logic        busy;

  mem_port_arbiter dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .i_req     (i_req),
    .i_addr    (i_addr),
    .i_ack     (i_ack),
    .i_rdata   (i_rdata),
    .i_err     (i_err),
    .d_req     (d_req),
    .d_we      (d_we),
    .d_addr    (d_addr),
    .d_wdata   (d_wdata),
    .d_ack     (d_ack),
    .d_rdata   (d_rdata),
    .d_err     (d_err),
    .mem_addr  (mem_addr),
    .mem_R     (mem_R),
    .mem_W     (mem_W),
    .mem_wdata (mem_wdata),
    .mem_rdata (mem_rdata),
    .busy      (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Behavioural MEM: 1024 words, combinational read, write on rising edge.
  logic [31:0] mem [0:1023];
  assign mem_rdata = mem[mem_addr[11:2]];

  bit mem_loaded = 1'b0;
  always @(posedge clk) begin
    if (!mem_loaded) begin
      for (int k = 0; k < 1024; k++) mem[k] = 32'h5A00_0000 ^ (k * 32'h0001_0203);
      mem[0] = 32'h2008_0005;
      mem_loaded = 1'b1;
    end else if (mem_W) begin
      mem[mem_addr[11:2]] = mem_wdata;
    end
  end

  // Reference model state.
  logic [31:0] ref_mem [0:1023];
  logic [31:0] exp_i_rdata;
  logic [31:0] exp_d_rdata;
  bit          d_known;
  bit          model_last_data;  // 1: previous grant went to data

  int n_asserts = 0;
  int n_fail    = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_asserts++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  function automatic bit model_err(input bit is_d, input bit we, input logic [31:0] addr);
    return (addr % 4 != 0) || (addr >= 32'd4096) || (is_d && we && addr < 32'h400);
  endfunction

  // Which requester wins when the given set is pending.
  function automatic bit model_pick_data(input bit ir, input bit dr);
`ifdef ARB_ROUND_ROBIN_EN
    if (ir && dr) return !model_last_data;
`endif
    return dr;
  endfunction

  // One complete access from IDLE; returns with the DUT back in IDLE.
  task automatic do_access(input bit is_d, input bit we, input logic [31:0] addr,
                           input logic [31:0] wdata, input string tag);
    bit          e;
    bit          st;
    int          n;
    logic [31:0] exp_rd;
    e  = model_err(is_d, we, addr);
    st = is_d && we;
    if (is_d) begin
      d_req = 1'b1; d_we = we; d_addr = addr; d_wdata = wdata;
    end else begin
      i_req = 1'b1; i_addr = addr;
    end
    model_last_data = is_d;
    tick;  // BUSY
    check({tag, "_busy"},   busy, 1'b1);
    check({tag, "_mem_R"},  mem_R, !st && !e);
    check({tag, "_mem_W"},  mem_W, st && !e);
    check({tag, "_maddr"},  mem_addr, addr);
    if (st && !e) begin
      check({tag, "_mwdata"}, mem_wdata, wdata);
      ref_mem[addr[11:2]] = wdata;
    end
    n = 1;
    while (!(i_ack || d_ack) && n < 6) begin
      tick;
      n++;
    end
    check({tag, "_ack_lat"}, n, 2);
    if (is_d) begin
      d_req = 1'b0;
      exp_rd = e ? 32'h0 : ref_mem[addr[11:2]];
      check({tag, "_d_ack"}, d_ack, 1'b1);
      check({tag, "_i_ack"}, i_ack, 1'b0);
      check({tag, "_d_err"}, d_err, e);
      if (!st || e) begin
        exp_d_rdata = exp_rd;
        d_known     = 1'b1;
        check({tag, "_d_rdata"}, d_rdata, exp_d_rdata);
      end else begin
        d_known = 1'b0;
      end
      check({tag, "_i_hold"}, i_rdata, exp_i_rdata);
    end else begin
      i_req = 1'b0;
      exp_i_rdata = e ? 32'h0 : ref_mem[addr[11:2]];
      check({tag, "_i_ack"}, i_ack, 1'b1);
      check({tag, "_d_ack"}, d_ack, 1'b0);
      check({tag, "_i_err"}, i_err, e);
      check({tag, "_i_rdata"}, i_rdata, exp_i_rdata);
      if (d_known) check({tag, "_d_hold"}, d_rdata, exp_d_rdata);
    end
    check({tag, "_resp_strb"}, {mem_R, mem_W}, 2'b00);
    check({tag, "_resp_addr"}, mem_addr, 32'h0);
    tick;  // IDLE
    check({tag, "_idle"}, {busy, i_ack, d_ack}, 3'b000);
  endtask

  // Both requesters raised together; each drops for good after its ack.
  task automatic tie_round(input int round);
    bit exp_first_d;
    bit got_d [2];
    int got;
    int cyc;
    exp_first_d = model_pick_data(1'b1, 1'b1);
    i_req = 1'b1; i_addr = 32'h0;
    d_req = 1'b1; d_we = 1'b0; d_addr = 32'h400; d_wdata = 32'h0;
    got = 0;
    cyc = 0;
    while (got < 2 && cyc < 12) begin
      tick;
      cyc++;
      check($sformatf("tie%0d_excl", round), i_ack & d_ack, 1'b0);
      if (d_ack) begin
        d_req = 1'b0;
        got_d[got] = 1'b1;
        got++;
        exp_d_rdata = ref_mem[32'h400 >> 2];
        d_known = 1'b1;
        check($sformatf("tie%0d_d_rdata", round), d_rdata, exp_d_rdata);
      end else if (i_ack) begin
        i_req = 1'b0;
        got_d[got] = 1'b0;
        got++;
        exp_i_rdata = ref_mem[0];
        check($sformatf("tie%0d_i_rdata", round), i_rdata, exp_i_rdata);
      end
    end
    check($sformatf("tie%0d_count", round), got, 2);
    if (got == 2) begin
      check($sformatf("tie%0d_first", round), got_d[0], exp_first_d);
      check($sformatf("tie%0d_second", round), got_d[1], !exp_first_d);
    end
    model_last_data = !exp_first_d;
    tick;  // IDLE
  endtask

  initial begin
    bit          is_d;
    bit          we;
    logic [31:0] addr;
    int          kind;

    rst_n = 1'b0;
    i_req = 1'b0; i_addr = 32'h0;
    d_req = 1'b0; d_we = 1'b0; d_addr = 32'h0; d_wdata = 32'h0;
    for (int k = 0; k < 1024; k++) ref_mem[k] = 32'h5A00_0000 ^ (k * 32'h0001_0203);
    ref_mem[0]      = 32'h2008_0005;
    exp_i_rdata     = 32'h0;
    exp_d_rdata     = 32'h0;
    d_known         = 1'b1;
    model_last_data = 1'b0;

    tick;
    tick;
    check("rst_outs", {i_ack, i_err, d_ack, d_err, mem_R, mem_W, busy}, 7'b0);
    check("rst_i_rdata", i_rdata, 32'h0);
    check("rst_d_rdata", d_rdata, 32'h0);
    check("rst_maddr", mem_addr, 32'h0);
    rst_n = 1'b1;
    tick;

    // Fetch of the first instruction.
    do_access(1'b0, 1'b0, 32'h0, 32'h0, "t1_fetch");
    // Store then load in the data area.
    do_access(1'b1, 1'b1, 32'h400, 32'hDEAD_BEEF, "t2_store");
    do_access(1'b1, 1'b0, 32'h400, 32'h0, "t2_load");
    check("t2_value", d_rdata, 32'hDEAD_BEEF);
    // Store into the text area is rejected; the word is untouched.
    do_access(1'b1, 1'b1, 32'h10, 32'h1234_5678, "t3_store");
    do_access(1'b0, 1'b0, 32'h10, 32'h0, "t3_fetch");
    // Misaligned load and out-of-range fetch.
    do_access(1'b1, 1'b0, 32'h402, 32'h0, "t4_load");
    do_access(1'b0, 1'b0, 32'h1000, 32'h0, "t4_fetch");
    // Boundary addresses.
    do_access(1'b1, 1'b1, 32'h3FC, 32'h1, "b_store_3fc");
    do_access(1'b1, 1'b1, 32'hFFC, 32'hA5A5_0FF0, "b_store_ffc");
    do_access(1'b0, 1'b0, 32'hFFC, 32'h0, "b_fetch_ffc");
    do_access(1'b1, 1'b0, 32'hFFFF_FFFC, 32'h0, "b_load_top");

    // Simultaneous requests, two rounds.
    tie_round(0);
    tie_round(1);

    // Reset during the BUSY cycle of a store.
    d_req = 1'b1; d_we = 1'b1; d_addr = 32'h500; d_wdata = 32'hCAFE_F00D;
    tick;
    check("t6_inflight_W", mem_W, 1'b1);
    rst_n = 1'b0;
    #1;
    check("t6_W_drop", mem_W, 1'b0);
    check("t6_outs", {i_ack, i_err, d_ack, d_err, mem_R, busy}, 6'b0);
    check("t6_maddr", mem_addr, 32'h0);
    check("t6_i_rdata", i_rdata, 32'h0);
    check("t6_d_rdata", d_rdata, 32'h0);
    d_req = 1'b0;
    exp_i_rdata = 32'h0;
    exp_d_rdata = 32'h0;
    d_known = 1'b1;
    model_last_data = 1'b0;
    tick;
    tick;
    check("t6_no_ack", {i_ack, d_ack}, 2'b00);
    rst_n = 1'b1;
    tick;
    do_access(1'b0, 1'b0, 32'h500, 32'h0, "t6_fetch");

    // Random traffic.
    for (int n = 0; n < 40; n++) begin
      is_d = 1'($urandom_range(0, 1));
      we   = is_d && ($urandom_range(0, 1) == 1);
      kind = $urandom_range(0, 5);
      case (kind)
        0, 1, 2: addr = 32'($urandom_range(256, 1023)) << 2;
        3:       addr = (32'($urandom_range(0, 1023)) << 2) | 32'($urandom_range(1, 3));
        4:       addr = 32'h1000 + (32'($urandom_range(0, 4095)) << 2);
        default: addr = 32'($urandom_range(0, 255)) << 2;
      endcase
      do_access(is_d, we, addr, $urandom, $sformatf("rnd%0d", n));
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_asserts, n_fail);
    $finish;
  end

endmodule
